// File: rtl/dispense_gate_scheduler_if.sv
// Requester-side bundle for the dispense gate scheduler:
// level requests and durations in, gate/done/status out.
interface dispense_gate_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int DUR_W = 12
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*DUR_W-1:0] dur;
  logic [N_REQ-1:0]       gate;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [IDW-1:0]         active_id;
  logic                   tick;

  modport master (
    output req, dur,
    input  gate, done, busy, active_id, tick
  );

  modport slave (
    input  req, dur,
    output gate, done, busy, active_id, tick
  );
endinterface

// File: rtl/dispense_gate_scheduler.sv
// Round-robin hopper-gate scheduler sharing one 100 Hz timebase.
// Define SCHED_FAST_TICK_EN to force the tick divider to 8.
module dispense_gate_scheduler #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100,
  parameter int N_REQ   = 4,
  parameter int DUR_W   = 12
) (
  input logic clk_50MHz,
  input logic rst_n,
  dispense_gate_scheduler_if.slave bus
);
`ifdef SCHED_FAST_TICK_EN
  localparam int DIV = 8;
`else
  localparam int DIV = CLK_HZ / TICK_HZ;
`endif
  localparam int PW  = $clog2(DIV);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_pre;
  logic             r_tick;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_last;
  logic [DUR_W-1:0] r_rem;
  logic [N_REQ-1:0] r_gate;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [DUR_W-1:0] w_dur;
  logic             w_abort;

  // tick is registered one count early so it lines up with r_pre == DIV-1
  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= (r_pre == PW'(DIV - 1)) ? '0 : r_pre + PW'(1);
      r_tick <= (r_pre == PW'(DIV - 2));
    end
  end

  // scan downward so the nearest channel after r_last is assigned last
  always_comb begin
    w_any = 1'b0;
    w_win = r_last;
    for (int i = N_REQ; i >= 1; i--) begin
      int k;
      k = (int'(r_last) + i) % N_REQ;
      if (bus.req[k]) begin
        w_any = 1'b1;
        w_win = IDW'(k);
      end
    end
  end

  assign w_dur   = bus.dur[int'(w_win)*DUR_W +: DUR_W];
  assign w_abort = !bus.req[r_id];

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_last  <= IDW'(N_REQ - 1);
      r_rem   <= '0;
      r_gate  <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id   <= w_win;
            r_rem  <= w_dur;
            r_busy <= 1'b1;
            if (w_dur == '0) begin
              r_state       <= S_DONE;
              r_done[w_win] <= 1'b1;
            end else begin
              r_state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_last  <= r_id;
          end else if (r_tick) begin
            r_state      <= S_RUN;
            r_gate[r_id] <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_gate  <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_id;
          end else if (r_tick) begin
            r_rem <= r_rem - DUR_W'(1);
            if (r_rem == DUR_W'(1)) begin
              r_state      <= S_DONE;
              r_gate       <= '0;
              r_done[r_id] <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_last  <= r_id;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gate      = r_gate;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.active_id = r_id;
  assign bus.tick      = r_tick;
endmodule

// File: tb/tb_dispense_gate_scheduler.sv
// Bench for dispense_gate_scheduler: vector table plus interval
// scoreboard, run with an 8-cycle tick divider.
module tb_dispense_gate_scheduler;
  localparam int N   = 4;
  localparam int W   = 12;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dispense_gate_scheduler_if #(.N_REQ(N), .DUR_W(W)) bus ();

  dispense_gate_scheduler #(
    .CLK_HZ (DIV * 100),
    .TICK_HZ(100),
    .N_REQ  (N),
    .DUR_W  (W)
  ) dut (
    .clk_50MHz(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  typedef struct {
    int ch;
    int dur;
    int abrt;
    int len;
    bit dn;
  } vec_t;

  typedef struct {
    int ch;
    int len;
    bit dn;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm, input int ch, input int n);
    total++;
    bad++;
    $display("FAIL %s: ch%0d still low after %0d cycles, want high", nm, ch, n);
  endtask

  function automatic int idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // interval monitor: one scoreboard entry per gate fall or done pulse
  logic [N-1:0] p_gate = '0;
  logic p_tick = 1'b0;
  int m_ch = -1;
  int m_len = 0;
  int t_cnt = 0;
  bit m_rise = 1'b0;
  bit m_multi = 1'b0;
  bit t_have = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (bus.gate != '0 && p_gate == '0) begin
      m_ch = idx(bus.gate);
      m_len = 0;
      m_rise = p_tick;
      m_multi = 1'b0;
    end
    if (bus.gate != '0) begin
      m_len++;
      if ($countones(bus.gate) != 1) m_multi = 1'b1;
    end
    if ((p_gate != '0 && bus.gate == '0) || bus.done != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_end_queue", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("end_ch", (bus.done != '0) ? idx(bus.done) : m_ch, e.ch);
        chk("end_done", int'(bus.done != '0), int'(e.dn));
        if (bus.done != '0)
          chk("done_onehot", $countones(bus.done), 1);
        if (e.len >= 0)
          chk("gate_len", (p_gate != '0) ? m_len : 0, e.len);
        if (p_gate != '0) begin
          chk("gate_ch", m_ch, e.ch);
          chk("rise_after_tick", int'(m_rise), 1);
          chk("gate_onehot", int'(m_multi), 0);
        end
      end
    end
    if (!rst_n) begin
      t_have = 1'b0;
    end else begin
      t_cnt++;
      if (bus.tick) begin
        if (t_have) chk("tick_period", t_cnt, DIV);
        t_cnt = 0;
        t_have = 1'b1;
      end
    end
    p_gate = bus.gate;
    p_tick = bus.tick;
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_gate"}, int'(bus.gate), 0);
    chk({nm, "_done"}, int'(bus.done), 0);
    chk({nm, "_busy"}, int'(bus.busy), 0);
    chk({nm, "_tick"}, int'(bus.tick), 0);
    chk({nm, "_id"}, int'(bus.active_id), 0);
  endtask

  task automatic wait_done(input int ch, input int budget);
    int n = 0;
    while (!bus.done[ch] && n < budget) begin
      cyc();
      n++;
    end
    if (!bus.done[ch]) timeout("wait_done", ch, n);
  endtask

  task automatic wait_gate(input int ch, input int budget);
    int n = 0;
    while (!bus.gate[ch] && n < budget) begin
      cyc();
      n++;
    end
    if (!bus.gate[ch]) timeout("wait_gate", ch, n);
  endtask

  // requesters drop req the cycle after done; optionally re-raise a cycle later
  task automatic run_reqs(input logic [N-1:0] mask, input int target,
                          input bit rerai, input int budget);
    logic [N-1:0] drop = '0;
    logic [N-1:0] raise = '0;
    int got = 0;
    int n = 0;
    bus.req = mask;
    while (got < target && n < budget) begin
      cyc();
      n++;
      bus.req = (bus.req | raise) & ~drop;
      raise = rerai ? drop : '0;
      drop = bus.done;
      got += $countones(bus.done);
    end
    if (got < target) timeout("run_reqs", idx(mask), n);
    cyc();
    bus.req = '0;
    repeat (3) cyc();
    chk("idle_after_run", int'(bus.busy), 0);
  endtask

  initial begin
    vec_t vt[7];
    int ch;
    int n;
    int k;

    vt[0] = '{0, 3,    0, 24,    1'b1};
    vt[1] = '{3, 0,    0, 0,     1'b1};
    vt[2] = '{2, 1,    0, 8,     1'b1};
    vt[3] = '{1, 2,    0, 16,    1'b1};
    vt[4] = '{3, 5,    2, 16,    1'b0};
    vt[5] = '{2, 4095, 0, 32760, 1'b1};
    vt[6] = '{0, 1,    0, 8,     1'b1};

    bus.req = '0;
    bus.dur = '0;
    rst_n = 1'b0;
    repeat (3) cyc();
    chk_zero("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      ch = vt[v].ch;
      sb.push_back('{ch, vt[v].len, vt[v].dn});
      cyc();
      bus.dur[ch*W +: W] = W'(vt[v].dur);
      bus.req[ch] = 1'b1;
      cyc();
      chk("grant_busy", int'(bus.busy), 1);
      chk("grant_id", int'(bus.active_id), ch);
      if (vt[v].abrt == 0) begin
        wait_done(ch, vt[v].dur * DIV + 40);
        cyc();
        bus.req[ch] = 1'b0;
        cyc();
        cyc();
        chk("vec_idle_busy", int'(bus.busy), 0);
        chk("vec_idle_gate", int'(bus.gate), 0);
      end else begin
        wait_gate(ch, 20);
        n = 0;
        k = 0;
        while (n < vt[v].abrt && k < 100) begin
          cyc();
          k++;
          if (bus.tick) n++;
        end
        if (n < vt[v].abrt) timeout("abort_ticks", ch, k);
        bus.req[ch] = 1'b0;
        cyc();
        chk("abort_gate", int'(bus.gate), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        repeat (3) cyc();
      end
    end

    // simultaneous requests after reset: ch1 first, then ch2
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.dur[1*W +: W] = W'(2);
    bus.dur[2*W +: W] = W'(2);
    sb.push_back('{1, 16, 1'b1});
    sb.push_back('{2, 16, 1'b1});
    run_reqs(4'b0110, 2, 1'b0, 200);

    // two requesters re-raising after each done must alternate
    bus.dur[0*W +: W] = W'(1);
    bus.dur[1*W +: W] = W'(1);
    sb.push_back('{0, 8, 1'b1});
    sb.push_back('{1, 8, 1'b1});
    sb.push_back('{0, 8, 1'b1});
    sb.push_back('{1, 8, 1'b1});
    run_reqs(4'b0011, 4, 1'b1, 300);

    // duration changed after grant is ignored
    bus.dur[2*W +: W] = W'(2);
    sb.push_back('{2, 16, 1'b1});
    bus.req[2] = 1'b1;
    cyc();
    bus.dur[2*W +: W] = W'(7);
    wait_done(2, 60);
    cyc();
    bus.req[2] = 1'b0;
    repeat (3) cyc();

    // reset mid-run, req[0] held and regranted
    bus.dur[0*W +: W] = W'(3);
    sb.push_back('{0, -1, 1'b0});
    bus.req[0] = 1'b1;
    wait_gate(0, 30);
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk_zero("midrun_reset");
    sb.push_back('{0, 24, 1'b1});
    n = 0;
    while (!bus.tick && n < 20) begin
      cyc();
      n++;
    end
    chk("tick_after_reset", n, DIV - 1);
    wait_done(0, 60);
    cyc();
    bus.req[0] = 1'b0;
    repeat (3) cyc();
    chk("final_busy", int'(bus.busy), 0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
